// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding a single UART transmitter.
// A requester holds the lock until its last word or until it stalls for IDLE_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NUMBER_OF_PORTS = 4,
    parameter int NUMBER_OF_BITS  = 8,
    parameter int IDLE_TIMEOUT    = 1024
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [NUMBER_OF_PORTS-1:0]                 in_valid,
    output logic [NUMBER_OF_PORTS-1:0]                 in_ready,
    input  logic [NUMBER_OF_PORTS*NUMBER_OF_BITS-1:0]  in_data,
    input  logic [NUMBER_OF_PORTS-1:0]                 in_last,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [NUMBER_OF_BITS-1:0]                  out_data,
    output logic [$clog2(NUMBER_OF_PORTS)-1:0]         grant_index,
    output logic                                       busy,
    output logic                                       timeout
);

    localparam int INDEX_BITS = $clog2(NUMBER_OF_PORTS);
    localparam int COUNT_BITS = $clog2(IDLE_TIMEOUT);
    localparam logic [COUNT_BITS-1:0] STALL_LIMIT = COUNT_BITS'(IDLE_TIMEOUT - 1);
    localparam logic [INDEX_BITS-1:0] LAST_PORT   = INDEX_BITS'(NUMBER_OF_PORTS - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state, state_next;
    logic [INDEX_BITS-1:0]  rr_ptr, rr_ptr_next;
    logic [INDEX_BITS-1:0]  grant_next;
    logic [COUNT_BITS-1:0]  stall_count, stall_count_next;
    logic                   timeout_next;
    logic [INDEX_BITS-1:0]  search_index, search_candidate;
    logic                   search_found;
    logic                   selected_valid, selected_last, transfer;

    // Modulo-N increment that also works when N is not a power of two.
    function automatic logic [INDEX_BITS-1:0] wrap_increment(input logic [INDEX_BITS-1:0] index);
        return (index == LAST_PORT) ? '0 : index + 1'b1;
    endfunction

    always_comb begin
        search_index     = rr_ptr;
        search_candidate = rr_ptr;
        search_found     = 1'b0;
        for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
            if (!search_found && in_valid[search_candidate]) begin
                search_index = search_candidate;
                search_found = 1'b1;
            end
            search_candidate = wrap_increment(search_candidate);
        end
    end

    assign selected_valid = in_valid[grant_index];
    assign selected_last  = in_last[grant_index];
    assign busy           = (state == LOCKED);

    // Gating with reset guarantees no handshake completes on the edge that abandons a lock.
    assign out_valid = busy && selected_valid && !reset;
    assign out_data  = in_data[int'(grant_index)*NUMBER_OF_BITS +: NUMBER_OF_BITS];
    assign transfer  = out_valid && out_ready;

    always_comb begin
        in_ready = '0;
        if (busy && !reset) begin
            in_ready[grant_index] = out_ready;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_next       = state;
        grant_next       = grant_index;
        rr_ptr_next      = rr_ptr;
        stall_count_next = stall_count;
        timeout_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|in_valid) begin
                    grant_next       = search_index;
                    stall_count_next = '0;
                    state_next       = LOCKED;
                end
            end
            LOCKED: begin
                if (transfer) begin
                    stall_count_next = '0;
                    if (selected_last) begin
                        state_next  = IDLE;
                        rr_ptr_next = wrap_increment(grant_index);
                    end
                end else if (!selected_valid) begin
                    // Saturating compare keeps the counter inside COUNT_BITS without wrapping.
                    if (stall_count == STALL_LIMIT) begin
                        state_next       = IDLE;
                        rr_ptr_next      = wrap_increment(grant_index);
                        stall_count_next = '0;
                        timeout_next     = 1'b1;
                    end else begin
                        stall_count_next = stall_count + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant_index <= '0;
            rr_ptr      <= '0;
            stall_count <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            grant_index <= grant_next;
            rr_ptr      <= rr_ptr_next;
            stall_count <= stall_count_next;
            timeout     <= timeout_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus a randomized run against a packet-level reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TMO = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_last  = '0;
    logic [N*W-1:0] in_data  = '0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     grant_index;
    logic           busy;
    logic           timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUMBER_OF_PORTS (N),
        .NUMBER_OF_BITS  (W),
        .IDLE_TIMEOUT    (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .grant_index (grant_index),
        .busy        (busy),
        .timeout     (timeout)
    );

    // Reference model: owner is -1 when nobody holds the lock.
    typedef struct packed {
        logic         ov;
        logic [W-1:0] od;
        logic [N-1:0] ir;
        logic         busy;
        logic [1:0]   grant;
        logic         to;
    } exp_t;

    int   m_owner;
    int   m_rr;
    int   m_stall;
    logic m_to;

    function automatic exp_t model_outputs();
        exp_t e;
        e = '0;
        e.to = m_to;
        if (m_owner >= 0) begin
            e.ov    = in_valid[m_owner];
            e.od    = in_data[m_owner*W +: W];
            e.ir    = out_ready ? N'(1 << m_owner) : '0;
            e.busy  = 1'b1;
            e.grant = 2'(m_owner);
        end
        return e;
    endfunction

    task automatic model_clock();
        bit found;
        m_to = 1'b0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && in_valid[(m_rr + k) % N]) begin
                    m_owner = (m_rr + k) % N;
                    found   = 1;
                end
            end
            m_stall = 0;
        end else if (in_valid[m_owner] && out_ready) begin
            m_stall = 0;
            if (in_last[m_owner]) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else if (!in_valid[m_owner]) begin
            m_stall++;
            if (m_stall == TMO) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
                m_to    = 1'b1;
            end
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [W-1:0] d, input logic l);
        in_valid[p]       = v;
        in_data[p*W +: W] = d;
        in_last[p]        = l;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        n_vec++;
        if ({busy, out_valid, timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: busy/out_valid/timeout got %b expected 000", {busy, out_valid, timeout});
        end
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        n_vec++;
        if (grant_index !== 2'd0) begin
            n_err++;
            $display("FAIL reset_grant: got %0d expected 0", grant_index);
        end
        reset = 1'b0;
        in_valid = '0;
        in_last = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_single_word();
        do_reset();
        out_ready = 1'b1;
        set_port(2, 1'b1, 8'h41, 1'b1);
        #1;
        n_vec++;
        if ({out_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL single_idle: out_valid/busy got %b expected 00", {out_valid, busy});
        end
        @(negedge clock);
        #1;
        n_vec++;
        if ({out_valid, busy, grant_index, out_data, in_ready} !== {1'b1, 1'b1, 2'd2, 8'h41, 4'b0100}) begin
            n_err++;
            $display("FAIL single_locked: ov=%b busy=%b grant=%0d data=%h rdy=%b expected ov=1 busy=1 grant=2 data=41 rdy=0100",
                     out_valid, busy, grant_index, out_data, in_ready);
        end
        @(negedge clock);
        in_valid = '0;
        #1;
        n_vec++;
        if ({busy, out_valid, in_ready} !== 6'b0) begin
            n_err++;
            $display("FAIL single_release: busy=%b ov=%b rdy=%b expected all 0", busy, out_valid, in_ready);
        end
        in_valid = '1;
        in_last  = '1;
        @(negedge clock);
        #1;
        n_vec++;
        if ({busy, grant_index} !== {1'b1, 2'd3}) begin
            n_err++;
            $display("FAIL single_rr_ptr: busy=%b grant=%0d expected busy=1 grant=3", busy, grant_index);
        end
        @(negedge clock);
        in_valid = '0;
    endtask

    task automatic test_round_robin();
        int           wi[N];
        int           pk[N];
        logic [W-1:0] got_d[$];
        int           got_g[$];
        do_reset();
        out_ready = 1'b1;
        for (int p = 0; p < N; p++) begin
            wi[p] = 0;
            pk[p] = 0;
        end
        for (int cyc = 0; cyc < 30 && got_d.size() < 10; cyc++) begin
            for (int p = 0; p < N; p++) begin
                set_port(p, 1'b1, W'((p << 6) | (pk[p] << 2) | wi[p]), wi[p] == 1);
            end
            #1;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_g.push_back(int'(grant_index));
            end
            for (int p = 0; p < N; p++) begin
                if (in_ready[p] && in_valid[p]) begin
                    if (wi[p] == 1) begin
                        wi[p] = 0;
                        pk[p]++;
                    end else begin
                        wi[p] = 1;
                    end
                end
            end
            @(negedge clock);
        end
        in_valid = '0;
        n_vec++;
        if (got_d.size() < 10) begin
            n_err++;
            $display("FAIL rr_count: got %0d transfers expected 10", got_d.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                int           port;
                logic [W-1:0] exp_d;
                port  = (k / 2) % N;
                exp_d = W'((port << 6) | (((k / 2) / N) << 2) | (k % 2));
                n_vec++;
                if (got_d[k] !== exp_d || got_g[k] != port) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: got port %0d data %h expected port %0d data %h",
                             k, got_g[k], got_d[k], port, exp_d);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int           bad;
        int           sent;
        logic [W-1:0] got_d[$];
        int           got_g[$];
        logic [W-1:0] exp_d[4];
        int           exp_g[4];
        do_reset();
        out_ready = 1'b0;
        set_port(1, 1'b1, 8'hA0, 1'b0);
        @(negedge clock);
        set_port(0, 1'b1, 8'h55, 1'b1);
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            in_data[7:0] = W'($urandom);
            #1;
            if (timeout !== 1'b0 || busy !== 1'b1 || grant_index !== 2'd1 || out_valid !== 1'b1 ||
                out_data !== 8'hA0 || in_ready !== 4'b0000) begin
                bad++;
            end
            @(negedge clock);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_hold: got %0d deviating cycles expected 0", bad);
        end
        in_data[7:0] = 8'h55;
        out_ready = 1'b1;
        sent = 0;
        for (int cyc = 0; cyc < 12 && got_d.size() < 4; cyc++) begin
            if (sent < 3) set_port(1, 1'b1, W'(8'hA0 + sent), sent == 2);
            else          set_port(1, 1'b0, 8'h00, 1'b0);
            #1;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_g.push_back(int'(grant_index));
            end
            if (in_ready[1] && in_valid[1]) sent++;
            @(negedge clock);
        end
        in_valid = '0;
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
        exp_g = '{1, 1, 1, 0};
        n_vec++;
        if (got_d.size() < 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d transfers expected 4", got_d.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (got_d[k] !== exp_d[k] || got_g[k] != exp_g[k]) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: got port %0d data %h expected port %0d data %h",
                             k, got_g[k], got_d[k], exp_g[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int first_k;
        int bad;
        do_reset();
        out_ready = 1'b1;
        set_port(3, 1'b1, 8'h33, 1'b0);
        @(negedge clock);
        #1;
        n_vec++;
        if ({busy, out_valid, grant_index} !== {1'b1, 1'b1, 2'd3}) begin
            n_err++;
            $display("FAIL tmo_lock: busy=%b ov=%b grant=%0d expected busy=1 ov=1 grant=3", busy, out_valid, grant_index);
        end
        @(negedge clock);
        in_valid[3] = 1'b0;
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, W'($urandom), 1'b1);
        first_k = -1;
        bad = 0;
        for (int k = 1; k <= 40 && first_k < 0; k++) begin
            in_data[23:0] = 24'($urandom);
            #1;
            if (timeout === 1'b1) begin
                first_k = k;
            end else begin
                if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 4'b1000) bad++;
                @(negedge clock);
            end
        end
        n_vec++;
        if (first_k != TMO + 1) begin
            n_err++;
            $display("FAIL tmo_latency: pulse seen at cycle %0d after transfer expected %0d", first_k, TMO + 1);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL tmo_hold: got %0d deviating stall cycles expected 0", bad);
        end
        if (first_k > 0) begin
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_busy: got %b expected 0", busy);
            end
            in_valid = '1;
            in_last  = '1;
            @(negedge clock);
            #1;
            n_vec++;
            if ({busy, timeout, grant_index} !== {1'b1, 1'b0, 2'd0}) begin
                n_err++;
                $display("FAIL tmo_wrap_grant: busy=%b timeout=%b grant=%0d expected busy=1 timeout=0 grant=0",
                         busy, timeout, grant_index);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        out_ready = 1'b1;
        set_port(2, 1'b1, 8'h22, 1'b1);
        @(negedge clock);
        @(negedge clock);
        set_port(2, 1'b0, 8'h00, 1'b0);
        set_port(1, 1'b1, 8'h10, 1'b0);
        @(negedge clock);
        #1;
        n_vec++;
        if ({busy, grant_index} !== {1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL rst_lock: busy=%b grant=%0d expected busy=1 grant=1", busy, grant_index);
        end
        @(negedge clock);
        set_port(1, 1'b1, 8'h11, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        #1;
        n_vec++;
        if ({out_valid, in_ready, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: ov=%b rdy=%b busy=%b expected all 0", out_valid, in_ready, busy);
        end
        reset    = 1'b0;
        in_valid = '1;
        in_last  = '1;
        @(negedge clock);
        #1;
        n_vec++;
        if ({busy, grant_index} !== {1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL rst_regrant: busy=%b grant=%0d expected busy=1 grant=0", busy, grant_index);
        end
        in_valid = '0;
    endtask

    task automatic test_random();
        int   len[N];
        int   pos[N];
        int   silent[N];
        exp_t e;
        do_reset();
        m_owner = -1;
        m_rr    = 0;
        m_stall = 0;
        m_to    = 1'b0;
        for (int p = 0; p < N; p++) begin
            len[p]    = $urandom_range(1, 4);
            pos[p]    = 0;
            silent[p] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < N; p++) begin
                set_port(p, (silent[p] == 0) && ($urandom_range(3) != 0), W'($urandom), pos[p] == len[p] - 1);
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            e = model_outputs();
            n_vec++;
            if (out_valid !== e.ov || busy !== e.busy || timeout !== e.to || in_ready !== e.ir ||
                (e.busy && (grant_index !== e.grant || out_data !== e.od))) begin
                n_err++;
                $display("FAIL random cyc %0d: got ov=%b busy=%b to=%b rdy=%b grant=%0d data=%h expected ov=%b busy=%b to=%b rdy=%b grant=%0d data=%h",
                         cyc, out_valid, busy, timeout, in_ready, grant_index, out_data,
                         e.ov, e.busy, e.to, e.ir, e.grant, e.od);
            end
            for (int p = 0; p < N; p++) begin
                if (e.ir[p] && in_valid[p]) begin
                    if (pos[p] == len[p] - 1) begin
                        pos[p] = 0;
                        len[p] = $urandom_range(1, 4);
                    end else begin
                        pos[p]++;
                    end
                end
                if (silent[p] > 0)                silent[p]--;
                else if ($urandom_range(59) == 0) silent[p] = $urandom_range(10, 30);
            end
            model_clock();
            @(negedge clock);
        end
        in_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_word();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_PORTS, default 4, giving the number of requesters (N >= 2).
REQ-002 The block SHALL have parameter NUMBER_OF_BITS, default 8, giving the data word width W.
REQ-003 The block SHALL have parameter IDLE_TIMEOUT, default 1024, giving the mid-packet stall limit in clock cycles (>= 2).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  N  per-requester word valid.
REQ-008 in_ready  output  N  per-requester word accepted.
REQ-009 in_data  input  N*W  requester i word at bits [i*W +: W].
REQ-010 in_last  input  N  marks the final word of requester i's packet.
REQ-011 out_valid  output  1  word valid toward the UART transmitter.
REQ-012 out_ready  input  1  UART transmitter ready.
REQ-013 out_data  output  W  word toward the UART transmitter.
REQ-014 grant_index  output  $clog2(N)  index of the currently locked requester; valid only while busy=1.
REQ-015 busy  output  1  high while a requester holds the lock.
REQ-016 timeout  output  1  one-cycle pulse when a lock is released by the stall timeout.

Function
REQ-017 The block SHALL implement two states: IDLE and LOCKED.
REQ-018 In IDLE, if any in_valid bit is high, the block SHALL register grant_index as the first requester with in_valid=1, searching rr_ptr, rr_ptr+1, ... modulo N, and SHALL enter LOCKED on the next edge.
REQ-019 In IDLE, the block SHALL hold out_valid=0, in_ready=0, busy=0.
REQ-020 In LOCKED: out_valid = in_valid[grant_index], out_data = in_data[grant_index], in_ready[grant_index] = out_ready, all other in_ready bits = 0, busy=1.
REQ-021 A transfer SHALL occur only when out_valid and out_ready are both high; latency from in_valid rising in IDLE to out_valid SHALL be exactly 1 cycle.
REQ-022 On a transfer with in_last[grant_index]=1, the block SHALL return to IDLE and set rr_ptr = (grant_index+1) mod N, with wrap from N-1 to 0.
REQ-023 The lock SHALL persist across words until last; requests from other ports SHALL be ignored while LOCKED, and their in_valid/in_data changes SHALL NOT affect out_* outputs.
REQ-024 The stall counter SHALL clear on entering LOCKED and on every transfer, and SHALL increment in each LOCKED cycle where in_valid[grant_index]=0.
REQ-025 A cycle with out_valid=1 and out_ready=0 (downstream backpressure) SHALL NOT increment the stall counter.
REQ-026 When the stall counter reaches IDLE_TIMEOUT-1 and would increment, the block SHALL return to IDLE, pulse timeout=1 for exactly that next cycle, and set rr_ptr = (grant_index+1) mod N.
REQ-027 If a transfer with last and a timeout expiry coincide, the transfer SHALL take precedence and timeout SHALL stay 0.
REQ-028 The counter width SHALL be $clog2(IDLE_TIMEOUT) and the counter SHALL never wrap.
REQ-029 A packet of one word (in_last=1 on the first word) SHALL be legal; one IDLE cycle SHALL follow every released lock.
REQ-030 The block SHALL NOT register or buffer data; out_data is combinational from the selected input.

Reset
REQ-031 On reset the block SHALL enter IDLE with rr_ptr=0, grant_index=0, stall counter=0, busy=0, timeout=0, out_valid=0, in_ready=0; reset asserted mid-packet SHALL abandon the lock without any further transfer.

Verification
REQ-032 After reset, raise in_valid[2] only, data 0x41 last=1, out_ready=1 -> out_valid high 1 cycle later with out_data=0x41, grant_index=2, busy=1; IDLE next cycle; rr_ptr=3.
REQ-033 After reset, hold in_valid=4'b1111 with 2-word packets on every port -> packets granted in order 0,1,2,3,0, never interleaved.
REQ-034 Port 1 locked, 3-word packet; port 0 valid throughout; out_ready held low 5000 cycles -> no timeout, no switch to port 0; all 3 words delivered in order once out_ready=1.
REQ-035 Port 3 locked, sends 1 word last=0 then drops in_valid; IDLE_TIMEOUT=16 -> timeout pulses once 16 cycles after the transfer; busy=0; next grant starts search at port 0 (wrap).
REQ-036 Assert reset during word 2 of a 4-word packet from port 1 -> next cycle out_valid=0, in_ready=0, busy=0; next grant with all ports valid goes to port 0.
